// File: rtl/led_chaser_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : led_chaser_ctrl
// Purpose  : Running-light sequencer feeding a 3-to-8 active-low LED decoder.
// Revision : 1.0 - initial release
// ============================================================================
module led_chaser_ctrl #(
    parameter int DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       dir,
    input  logic       bounce,
    input  logic       step,
    input  logic       blank,
    output logic [2:0] switch,
    output logic [2:0] enable,
    output logic       wrap
);

    localparam int unsigned          c_PRESC_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [c_PRESC_W-1:0] c_PRESC_TERM = c_PRESC_W'(DIV - 1);
    localparam logic [c_PRESC_W-1:0] c_PRESC_ONE  = c_PRESC_W'(1);
    localparam logic [2:0]           c_EN_ON      = 3'b100;
    localparam logic [2:0]           c_EN_OFF     = 3'b000;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_RUN   = 2'd1;
    localparam logic [1:0] c_PAUSE = 2'd2;

    logic [1:0]           r_state;
    logic [c_PRESC_W-1:0] r_presc;
    logic                 r_cur_dir;
    logic                 r_bounce_d;
    logic [2:0]           r_switch;
    logic [2:0]           r_enable;
    logic                 r_wrap;

    logic       w_bounce_rise;
    logic       w_eff_dir;
    logic       w_adv_dir;
    logic [2:0] w_next_idx;
    logic       w_turn;
    logic [1:0] w_next_state;
    logic       w_advance;
    logic       w_presc_term;

    always_comb begin
        w_bounce_rise = bounce & ~r_bounce_d;
        // A bounce edge coinciding with an advance must already use the new direction.
        w_eff_dir     = bounce ? (w_bounce_rise ? dir : r_cur_dir) : dir;
        w_presc_term  = (r_presc == c_PRESC_TERM);

        w_next_idx = r_switch;
        w_adv_dir  = w_eff_dir;
        w_turn     = 1'b0;
        if (bounce && !w_eff_dir && (r_switch == 3'd7)) begin
            w_next_idx = 3'd6;
            w_adv_dir  = 1'b1;
            w_turn     = 1'b1;
        end else if (bounce && w_eff_dir && (r_switch == 3'd0)) begin
            w_next_idx = 3'd1;
            w_adv_dir  = 1'b0;
            w_turn     = 1'b1;
        end else if (!w_eff_dir) begin
            w_next_idx = r_switch + 3'd1;
            w_turn     = (r_switch == 3'd7);
        end else begin
            w_next_idx = r_switch - 3'd1;
            w_turn     = (r_switch == 3'd0);
        end

        w_next_state = r_state;
        w_advance    = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (run) w_next_state = c_RUN;
            end
            c_RUN: begin
                if (!run)              w_next_state = c_PAUSE;
                else if (w_presc_term) w_advance    = 1'b1;
            end
            c_PAUSE: begin
                if (run)       w_next_state = c_RUN;
                else if (step) w_advance    = 1'b1;
            end
            default: w_next_state = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_presc    <= '0;
            r_cur_dir  <= 1'b0;
            r_bounce_d <= 1'b0;
            r_switch   <= 3'd0;
            r_enable   <= c_EN_OFF;
            r_wrap     <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_bounce_d <= bounce;

            if ((r_state == c_RUN) && run && !w_presc_term) r_presc <= r_presc + c_PRESC_ONE;
            else                                           r_presc <= '0;

            if (w_advance) begin
                r_switch  <= w_next_idx;
                r_cur_dir <= w_adv_dir;
            end else if (w_bounce_rise || ((r_state == c_IDLE) && run)) begin
                r_cur_dir <= dir;
            end

            r_wrap   <= w_advance & w_turn;
            r_enable <= ((w_next_state != c_IDLE) && !blank) ? c_EN_ON : c_EN_OFF;
        end
    end

    assign switch = r_switch;
    assign enable = r_enable;
    assign wrap   = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_led_chaser_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_chaser_ctrl
// Purpose  : Scoreboard bench for led_chaser_ctrl (DIV = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_chaser_ctrl;

    localparam int DIV = 4;

    logic       clk    = 1'b0;
    logic       rst    = 1'b1;
    logic       run    = 1'b0;
    logic       dir    = 1'b0;
    logic       bounce = 1'b0;
    logic       step   = 1'b0;
    logic       blank  = 1'b0;
    logic [2:0] sw;
    logic [2:0] en;
    logic       wr;

    typedef struct {
        logic [2:0] sw;
        logic [2:0] en;
        logic       wr;
        string      tag;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    led_chaser_ctrl #(.DIV(DIV)) dut (
        .clk    (clk),
        .rst    (rst),
        .run    (run),
        .dir    (dir),
        .bounce (bounce),
        .step   (step),
        .blank  (blank),
        .switch (sw),
        .enable (en),
        .wrap   (wr)
    );

    always #5 clk = ~clk;

    // Inputs applied on the falling edge; expected outputs are those after the next rising edge.
    task automatic drive(input logic r, input logic rn, input logic d, input logic b,
                         input logic s, input logic bl, input logic [2:0] esw,
                         input logic [2:0] een, input logic ewr, input string tag);
        exp_t e;
        @(negedge clk);
        rst = r; run = rn; dir = d; bounce = b; step = s; blank = bl;
        e.sw = esw; e.en = een; e.wr = ewr; e.tag = tag;
        q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                n_cmp++;
                if ({sw, en, wr} !== {e.sw, e.en, e.wr}) begin
                    n_bad++;
                    $display("FAIL %s: got switch=%0d enable=%b wrap=%b, want switch=%0d enable=%b wrap=%b",
                             e.tag, sw, en, wr, e.sw, e.en, e.wr);
                end
            end
        end
    end

    initial begin : stimulus
        int n;
        int m;
        logic [2:0] esw;
        logic       ewr;
        logic       bl;

        // Reset, then idle with run low; step must be ignored in IDLE.
        drive(1, 0, 0, 0, 0, 0, 3'd0, 3'b000, 0, "reset");
        drive(1, 0, 0, 0, 0, 0, 3'd0, 3'b000, 0, "reset");
        for (int j = 0; j < 10; j++)
            drive(0, 0, 0, 0, (j >= 5) ? 1'b1 : 1'b0, 0, 3'd0, 3'b000, 0, "idle");

        // Wrap mode, counting up: each value held 4 cycles, wrap on 7->0.
        for (int j = 0; j < 36; j++) begin
            esw = 3'((j / 4) % 8);
            drive(0, 1, 0, 0, 0, 0, esw, 3'b100, (j == 32) ? 1'b1 : 1'b0, "wrap_up");
        end

        // Bounce mode from a clean start; dir changes after the start are ignored.
        drive(1, 0, 0, 0, 0, 0, 3'd0, 3'b000, 0, "reset");
        for (int j = 0; j < 64; j++) begin
            n   = j / 4;
            m   = n % 14;
            esw = (m <= 7) ? 3'(m) : 3'(14 - m);
            ewr = ((j % 4) == 0) && (j > 0) && ((m == 8) || ((m == 1) && (n > 1)));
            drive(0, 1, (j < 4) ? 1'b0 : 1'b1, 1, 0, 0, esw, 3'b100, ewr, "bounce");
        end

        // Pause on the terminal prescaler cycle, then single-step.
        drive(1, 0, 0, 0, 0, 0, 3'd0, 3'b000, 0, "reset");
        for (int j = 0; j < 16; j++)
            drive(0, 1, 0, 0, 0, 0, 3'(j / 4), 3'b100, 0, "run_to_3");
        drive(0, 0, 0, 0, 0, 0, 3'd3, 3'b100, 0, "pause_at_term");
        drive(0, 0, 0, 0, 1, 0, 3'd4, 3'b100, 0, "step_pulse");
        drive(0, 0, 0, 0, 0, 0, 3'd4, 3'b100, 0, "pause_hold");
        drive(0, 0, 0, 0, 0, 0, 3'd4, 3'b100, 0, "pause_hold");
        drive(0, 0, 0, 0, 1, 0, 3'd5, 3'b100, 0, "step_held");
        drive(0, 0, 0, 0, 1, 0, 3'd6, 3'b100, 0, "step_held");
        drive(0, 0, 0, 0, 1, 0, 3'd7, 3'b100, 0, "step_held");
        drive(0, 0, 0, 0, 1, 0, 3'd0, 3'b100, 1, "step_wrap");
        drive(0, 0, 0, 0, 1, 0, 3'd1, 3'b100, 0, "step_held");
        drive(0, 0, 0, 0, 1, 0, 3'd2, 3'b100, 0, "step_held");
        drive(0, 1, 0, 0, 1, 0, 3'd2, 3'b100, 0, "run_and_step");
        drive(0, 1, 0, 0, 0, 0, 3'd2, 3'b100, 0, "resume");
        drive(0, 1, 0, 0, 0, 0, 3'd2, 3'b100, 0, "resume");
        drive(0, 1, 0, 0, 0, 0, 3'd2, 3'b100, 0, "resume");
        drive(0, 1, 0, 0, 0, 0, 3'd3, 3'b100, 0, "resume_adv");
        drive(0, 0, 0, 0, 0, 0, 3'd3, 3'b100, 0, "pause_again");
        drive(0, 0, 1, 0, 1, 0, 3'd2, 3'b100, 0, "step_down");
        drive(0, 0, 1, 0, 1, 0, 3'd1, 3'b100, 0, "step_down");
        drive(0, 0, 1, 0, 1, 0, 3'd0, 3'b100, 0, "step_down");
        drive(0, 0, 1, 0, 1, 0, 3'd7, 3'b100, 1, "step_down_wrap");
        drive(0, 0, 1, 0, 0, 0, 3'd7, 3'b100, 0, "pause_hold");

        // Blanking during RUN, then a mid-run reset at switch=5.
        drive(1, 0, 0, 0, 0, 0, 3'd0, 3'b000, 0, "reset");
        for (int j = 0; j < 22; j++) begin
            bl = (j >= 5) && (j <= 9);
            drive(0, 1, 0, 0, 0, bl, 3'(j / 4), bl ? 3'b000 : 3'b100, 0, "blank");
        end
        drive(1, 1, 0, 0, 0, 0, 3'd0, 3'b000, 0, "rst_mid");
        for (int j = 0; j < 6; j++)
            drive(0, 1, 0, 0, 0, 0, 3'(j / 4), 3'b100, 0, "restart");

        repeat (3) @(negedge clk);
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending entries, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
